// File: rtl/pid_loop_pkg.sv
// Shared definitions for the PI loop sequencer: FSM encoding and timing constants.
package pid_loop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_ADC_START = 3'd2,
        ST_ADC_WAIT  = 3'd3,
        ST_HANDOFF   = 3'd4,
        ST_PID_WAIT  = 3'd5,
        ST_CAPTURE   = 3'd6,
        ST_FAULT     = 3'd7
    } pid_state_e;

    localparam int MIN_PERIOD_DEFAULT = 32;
    // adc_complete must stay high this many cycles for the datapath's 2-FF synchroniser
    localparam int HANDOFF_LEN = 2;

endpackage

// File: rtl/pid_target_ramp.sv
// Soft-start setpoint: steps toward target_final by STEP per request, clamping on arrival.
module pid_target_ramp #(
    parameter int W    = 26,
    parameter int STEP = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                step,
    input  logic signed [W-1:0] target_final,
    output logic signed [W-1:0] target
);

    localparam logic signed [W:0] STEP_W = (W + 1)'(STEP);

    // one extra bit so the distance to the final value cannot overflow
    logic signed [W:0] diff;

    always_comb begin
        diff = {target_final[W-1], target_final} - {target[W-1], target};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
        end else if (clear) begin
            target <= '0;
        end else if (step) begin
            if (diff > STEP_W) begin
                target <= target + W'(STEP);
            end else if (diff < -STEP_W) begin
                target <= target - W'(STEP);
            end else begin
                target <= target_final;
            end
        end
    end

endmodule

// File: rtl/pid_loop_sequencer.sv
// Paces ADC conversions, hands samples to the PI datapath, captures duty, ramps the setpoint.
module pid_loop_sequencer
    import pid_loop_pkg::*;
#(
    parameter int INPUT_BIT_WIDTH     = 12,
    parameter int PARAMETER_BIT_WIDTH = 26,
    parameter int PERIOD_BIT_WIDTH    = 21,
    parameter int PID_LATENCY         = 16,
    parameter int ADC_TIMEOUT         = 1000,
    parameter int RAMP_STEP           = 1,
    parameter int MIN_PERIOD          = MIN_PERIOD_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enable,
    input  logic        [PERIOD_BIT_WIDTH-1:0]    period,
    input  logic signed [PARAMETER_BIT_WIDTH-1:0] target_final,
    output logic                                  adc_start,
    input  logic                                  adc_done,
    input  logic        [INPUT_BIT_WIDTH-1:0]     adc_data,
    output logic        [INPUT_BIT_WIDTH-1:0]     sample,
    output logic                                  adc_complete,
    output logic signed [PARAMETER_BIT_WIDTH-1:0] target,
    input  logic signed [PARAMETER_BIT_WIDTH-1:0] pid_out,
    output logic signed [PARAMETER_BIT_WIDTH-1:0] duty,
    output logic                                  duty_valid,
    output logic                                  fault,
    output logic        [7:0]                     overrun_cnt,
    output logic                                  busy,
    output pid_state_e                            state_dbg
);

    localparam int LW = $clog2(PID_LATENCY + 1);
    localparam int TW = $clog2(ADC_TIMEOUT + 1);
    localparam logic [PERIOD_BIT_WIDTH-1:0] P_MIN   = PERIOD_BIT_WIDTH'(MIN_PERIOD);
    localparam logic [LW-1:0]               HO_LAST  = LW'(HANDOFF_LEN - 1);
    localparam logic [LW-1:0]               LAT_LAST = LW'(PID_LATENCY - 1);
    localparam logic [TW-1:0]               TO_LAST  = TW'(ADC_TIMEOUT - 1);

    pid_state_e                  state, state_next;
    logic [PERIOD_BIT_WIDTH-1:0] per_cnt, per_len, floor_period;
    logic [LW-1:0]               lat_cnt;
    logic [TW-1:0]               to_cnt;
    logic                        tick, load_sample, do_capture, enter_fault;

    assign floor_period = (period < P_MIN) ? P_MIN : period;
    assign tick         = enable && (per_cnt == per_len - PERIOD_BIT_WIDTH'(1));

    // Period is re-latched at every wrap and continuously while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            per_len <= P_MIN;
        end else if (!enable || tick) begin
            per_cnt <= '0;
            per_len <= floor_period;
        end else begin
            per_cnt <= per_cnt + PERIOD_BIT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // ADC handshake: adc_start is a one-cycle request; the converter answers later with a
    // one-cycle adc_done carrying adc_data, which is only honoured while in ADC_WAIT.
    always_comb begin
        state_next  = state;
        load_sample = 1'b0;
        do_capture  = 1'b0;
        enter_fault = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      state_next = ST_WAIT_TICK;
                ST_WAIT_TICK: if (tick) state_next = ST_ADC_START;
                ST_ADC_START: state_next = ST_ADC_WAIT;
                ST_ADC_WAIT: begin
                    if (adc_done) begin
                        load_sample = 1'b1;
                        state_next  = ST_HANDOFF;
                    end else if (to_cnt == TO_LAST) begin
                        enter_fault = 1'b1;
                        state_next  = ST_FAULT;
                    end
                end
                ST_HANDOFF:   if (lat_cnt == HO_LAST) state_next = ST_PID_WAIT;
                ST_PID_WAIT:  if (lat_cnt == LAT_LAST) state_next = ST_CAPTURE;
                ST_CAPTURE: begin
                    do_capture = 1'b1;
                    state_next = ST_WAIT_TICK;
                end
                ST_FAULT:     state_next = ST_FAULT;
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    // to_cnt counts from the adc_start cycle, so FAULT lands ADC_TIMEOUT cycles after it;
    // lat_cnt counts from the adc_complete rise and spans both HANDOFF and PID_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            lat_cnt     <= '0;
            sample      <= '0;
            duty        <= '0;
            duty_valid  <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            duty_valid <= do_capture;
            if (state == ST_ADC_START)     to_cnt <= TW'(1);
            else if (state == ST_ADC_WAIT) to_cnt <= to_cnt + TW'(1);
            if (load_sample) begin
                lat_cnt <= '0;
                sample  <= adc_data;
            end else if (state == ST_HANDOFF || state == ST_PID_WAIT) begin
                lat_cnt <= lat_cnt + LW'(1);
            end
            if (do_capture)       duty <= pid_out[PARAMETER_BIT_WIDTH-1] ? '0 : pid_out;
            else if (enter_fault) duty <= '0;
            if (tick && state != ST_WAIT_TICK && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    assign adc_start    = (state == ST_ADC_START);
    assign adc_complete = (state == ST_HANDOFF) && enable;
    assign fault        = (state == ST_FAULT);
    assign busy         = (state != ST_IDLE) && (state != ST_WAIT_TICK);
    assign state_dbg    = state;

    pid_target_ramp #(
        .W    (PARAMETER_BIT_WIDTH),
        .STEP (RAMP_STEP)
    ) u_ramp (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (!enable),
        .step         (do_capture),
        .target_final (target_final),
        .target       (target)
    );

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Self-checking bench for pid_loop_sequencer against a latency/ramp reference model.
module tb_pid_loop_sequencer;
  import pid_loop_pkg::*;

  localparam int LAT   = 16;
  localparam int MIN_P = 32;

  logic               clk, rst_n, enable;
  logic [20:0]        period;
  logic signed [25:0] target_final, target, pid_out, duty;
  logic               adc_start, adc_done, adc_complete, duty_valid, fault, busy;
  logic [11:0]        adc_data, sample;
  logic [7:0]         overrun_cnt;
  pid_state_e         state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0, p_eff, d_lat, m_target, m_duty, m_ovr, pid_lo, pid_hi;
  logic adc_respond;
  logic [11:0] adc_last;
  logic [25:0] exp_q[$];

  pid_loop_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .target_final(target_final), .adc_start(adc_start), .adc_done(adc_done),
    .adc_data(adc_data), .sample(sample), .adc_complete(adc_complete),
    .target(target), .pid_out(pid_out), .duty(duty), .duty_valid(duty_valid),
    .fault(fault), .overrun_cnt(overrun_cnt), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ADC converter model: answers adc_start after d_lat cycles with random data
  initial begin
    adc_done = 0;
    adc_data = '0;
    adc_last = '0;
    forever begin
      @(negedge clk);
      if (adc_start && adc_respond) begin
        repeat (d_lat) @(negedge clk);
        adc_last = 12'($urandom);
        adc_data = adc_last;
        adc_done = 1;
        @(negedge clk);
        adc_done = 0;
      end
    end
  end

  function automatic int ramp_step(input int cur, input int fin);
    if (fin > cur) return (fin - cur > 1) ? cur + 1 : fin;
    return (cur - fin > 1) ? cur - 1 : fin;
  endfunction

  task automatic apply_reset();
    rst_n = 0; enable = 0; period = 21'd100; target_final = '0; pid_out = '0;
    adc_respond = 0; m_duty = 0; m_target = 0; m_ovr = 0; exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic start_loop(input int per, input int fin, input int d);
    @(negedge clk);
    enable = 0; period = 21'(per); target_final = 26'(fin); d_lat = d; adc_respond = 1;
    @(negedge clk);
    p_eff = (per < MIN_P) ? MIN_P : per;
    enable = 1;
    t0 = cyc + p_eff - 1;
    m_target = 0;
    exp_q.delete();
    checks++;
    if (target !== '0) begin failures++; $display("FAIL restart_target got=%0d exp=0", target); end
  endtask

  // Free-running loop check: every cycle compared against the spec latencies.
  task automatic run_cycles(input int n);
    int off, v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      off = (cyc >= t0) ? (cyc - t0) % p_eff : -1;
      if (off == 0) begin
        v = int'($urandom_range(0, pid_hi - pid_lo)) + pid_lo;
        pid_out = 26'(v);
        exp_q.push_back((v < 0) ? 26'd0 : 26'(v));
      end
      if (off == 3 + d_lat + LAT) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL scoreboard_empty cyc=%0d", cyc); end
        else m_duty = int'($signed(exp_q.pop_front()));
        m_target = ramp_step(m_target, int'(target_final));
      end
      checks += 8;
      if (adc_start !== (off == 1)) begin
        failures++; $display("FAIL adc_start cyc=%0d got=%0b exp=%0b", cyc, adc_start, off == 1); end
      if (adc_complete !== (off == 2 + d_lat || off == 3 + d_lat)) begin
        failures++; $display("FAIL adc_complete cyc=%0d got=%0b off=%0d", cyc, adc_complete, off); end
      if (duty_valid !== (off == 3 + d_lat + LAT)) begin
        failures++; $display("FAIL duty_valid cyc=%0d got=%0b off=%0d", cyc, duty_valid, off); end
      if (busy !== (off >= 1 && off <= 2 + d_lat + LAT)) begin
        failures++; $display("FAIL busy cyc=%0d got=%0b off=%0d", cyc, busy, off); end
      if (duty !== 26'(m_duty)) begin
        failures++; $display("FAIL duty cyc=%0d got=%0d exp=%0d", cyc, duty, m_duty); end
      if (target !== 26'(m_target)) begin
        failures++; $display("FAIL target cyc=%0d got=%0d exp=%0d", cyc, target, m_target); end
      if (fault !== 1'b0) begin failures++; $display("FAIL fault cyc=%0d got=%0b exp=0", cyc, fault); end
      if (overrun_cnt !== 8'(m_ovr)) begin
        failures++; $display("FAIL overrun cyc=%0d got=%0d exp=%0d", cyc, overrun_cnt, m_ovr); end
      if (off == 2 + d_lat) begin
        checks++;
        if (sample !== adc_last) begin
          failures++; $display("FAIL sample cyc=%0d got=%0h exp=%0h", cyc, sample, adc_last); end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (adc_start !== 0 || adc_complete !== 0 || sample !== '0 || target !== '0 || duty !== '0 ||
        duty_valid !== 0 || fault !== 0 || overrun_cnt !== '0 || busy !== 0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL %s outputs st=%0d smp=%0h tgt=%0d duty=%0d ovr=%0d busy=%0b exp all zero/IDLE",
               tag, state_dbg, sample, target, duty, overrun_cnt, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 0; period = 21'd100; target_final = '0; pid_out = '0; adc_respond = 0;
    #1;
    check_all_zero("reset_asserted");
    apply_reset();
    check_all_zero("reset_released");
  endtask

  task automatic test_steady();
    pid_lo = 300; pid_hi = 300;
    start_loop(100, 50, 5);
    run_cycles(55 * 100);
    checks++;
    if (target !== 26'sd50) begin failures++; $display("FAIL steady_final_target got=%0d exp=50", target); end
  endtask

  task automatic test_negative_duty();
    pid_lo = -40; pid_hi = -40;
    run_cycles(3 * 100);
    checks++;
    if (duty !== '0) begin failures++; $display("FAIL negative_duty got=%0d exp=0", duty); end
  endtask

  task automatic test_ramp_down();
    pid_lo = -500; pid_hi = 500;
    target_final = 26'sd45;
    run_cycles(8 * 100);
    checks++;
    if (target !== 26'sd45) begin failures++; $display("FAIL ramp_down_target got=%0d exp=45", target); end
  endtask

  task automatic test_period_floor();
    pid_lo = 0; pid_hi = 1000;
    start_loop(5, -3, int'($urandom_range(1, 8)));
    run_cycles(6 * 32 + 5);
  endtask

  task automatic test_timeout();
    int t1;
    pid_lo = 300; pid_hi = 300;
    start_loop(1200, 50, 5);
    run_cycles(1230);
    adc_respond = 0;
    t1 = t0 + p_eff;
    while (cyc < t1 + 1001) begin
      @(negedge clk);
      if (cyc == t1 + 1000) begin
        checks++;
        if (fault !== 0 || busy !== 1) begin
          failures++; $display("FAIL timeout_early fault=%0b busy=%0b exp fault=0 busy=1", fault, busy); end
      end
    end
    checks += 2;
    if (fault !== 1) begin failures++; $display("FAIL timeout_fault got=%0b exp=1", fault); end
    if (duty !== '0 || adc_start !== 0 || adc_complete !== 0) begin
      failures++; $display("FAIL timeout_outputs duty=%0d start=%0b cmpl=%0b exp 0", duty, adc_start, adc_complete); end
    repeat (5) @(negedge clk);
    checks++;
    if (fault !== 1) begin failures++; $display("FAIL fault_sticky got=%0b exp=1", fault); end
    enable = 0;
    @(negedge clk);
    checks++;
    if (fault !== 0 || state_dbg !== ST_IDLE || duty !== '0) begin
      failures++; $display("FAIL fault_clear fault=%0b st=%0d duty=%0d exp 0/IDLE/0", fault, state_dbg, duty); end
    m_duty = 0;
    start_loop(100, 50, 5);
    run_cycles(130);
  endtask

  task automatic test_abort();
    int t1;
    pid_lo = 300; pid_hi = 300;
    start_loop(100, 50, 5);
    run_cycles(130);
    t1 = t0 + p_eff;
    while (cyc < t1 + 13) @(negedge clk);
    enable = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (adc_complete !== 0 || duty_valid !== 0 || duty !== 26'(m_duty) || state_dbg !== ST_IDLE || busy !== 0) begin
        failures++;
        $display("FAIL abort_pid_wait cmpl=%0b dv=%0b duty=%0d st=%0d exp 0/0/%0d/IDLE",
                 adc_complete, duty_valid, duty, state_dbg, m_duty);
      end
    end
    start_loop(100, 50, 5);
    while (cyc < t0 + 7) @(negedge clk);
    checks++;
    if (adc_complete !== 1) begin failures++; $display("FAIL handoff_high got=%0b exp=1", adc_complete); end
    enable = 0;
    #1;
    checks++;
    if (adc_complete !== 0) begin failures++; $display("FAIL abort_handoff got=%0b exp=0", adc_complete); end
    @(negedge clk);
    checks++;
    if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL abort_idle got=%0d exp=%0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_reset_mid();
    pid_lo = 300; pid_hi = 300;
    start_loop(100, 50, 40);
    run_cycles(170);
    while (cyc < t0 + p_eff + 10) @(negedge clk);
    checks++;
    if (state_dbg !== ST_ADC_WAIT || duty !== 26'sd300) begin
      failures++; $display("FAIL pre_reset st=%0d duty=%0d exp ADC_WAIT/300", state_dbg, duty); end
    rst_n = 0;
    #1;
    check_all_zero("reset_mid");
    enable = 0;
    repeat (50) @(negedge clk);
    apply_reset();
  endtask

  task automatic test_overrun();
    int free_at, last_acc;
    apply_reset();
    pid_lo = 300; pid_hi = 300; pid_out = 26'sd300;
    start_loop(32, 50, 20);
    free_at = 0; last_acc = -1000; m_ovr = 0;
    for (int i = 0; i < 520 * 32; i++) begin
      @(negedge clk);
      checks += 2;
      if (overrun_cnt !== 8'(m_ovr)) begin
        failures++; $display("FAIL overrun_cnt cyc=%0d got=%0d exp=%0d", cyc, overrun_cnt, m_ovr); end
      if (duty_valid !== (cyc == last_acc + 3 + d_lat + LAT)) begin
        failures++; $display("FAIL overrun_duty_valid cyc=%0d got=%0b", cyc, duty_valid); end
      if (cyc >= t0 && (cyc - t0) % p_eff == 0) begin
        if (cyc >= free_at) begin
          last_acc = cyc;
          free_at = cyc + 3 + d_lat + LAT;
        end else if (m_ovr < 255) begin
          m_ovr++;
        end
      end
    end
    checks++;
    if (overrun_cnt !== 8'd255) begin failures++; $display("FAIL overrun_saturate got=%0d exp=255", overrun_cnt); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_negative_duty();
    test_ramp_down();
    test_period_floor();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
